// File: rtl/bounce_mover_if.sv
// Bus bundle for bounce_mover: move cadence, pause/load controls,
// load values, and the registered position/speed/bounce state.
// master = controller side (drives controls), slave = bounce_mover.
interface bounce_mover_if #(
  parameter int POS_W = 10,
  parameter int SPD_W = 4,
  parameter int CNT_W = 8
);
  logic             tick;
  logic             pause;
  logic             load;
  logic [POS_W-1:0] pos_x_in;
  logic [POS_W-1:0] pos_y_in;
  logic [SPD_W-1:0] spd_x_in;
  logic [SPD_W-1:0] spd_y_in;
  logic             dir_x_in;
  logic             dir_y_in;
  logic [POS_W-1:0] pos_x;
  logic [POS_W-1:0] pos_y;
  logic [SPD_W-1:0] spd_x;
  logic [SPD_W-1:0] spd_y;
  logic             dir_x;
  logic             dir_y;
  logic             bounce_x;
  logic             bounce_y;
  logic [CNT_W-1:0] bounce_cnt;

  modport master (
    output tick, pause, load, pos_x_in, pos_y_in, spd_x_in, spd_y_in, dir_x_in, dir_y_in,
    input  pos_x, pos_y, spd_x, spd_y, dir_x, dir_y, bounce_x, bounce_y, bounce_cnt
  );

  modport slave (
    input  tick, pause, load, pos_x_in, pos_y_in, spd_x_in, spd_y_in, dir_x_in, dir_y_in,
    output pos_x, pos_y, spd_x, spd_y, dir_x, dir_y, bounce_x, bounce_y, bounce_cnt
  );
endinterface

// File: rtl/bounce_mover.sv
// bounce_mover: 2-D bouncing-object position generator for the VGA game path.
// One step per rising edge of the slow tick level; each axis reflects off its
// own walls and emits a one-cycle bounce pulse. bounce_cnt saturates.
// Optional feature: define BOUNCE_MOVER_ACCEL_EN to raise both nonzero speeds
// by one (saturating at SPD_MAX) on every ACCEL_EVERY-th bounce step.
// Interface widths (POS_W/SPD_W/CNT_W) must match this module's parameters.
module bounce_mover #(
  parameter int POS_W       = 10,
  parameter int X_MIN       = 234,
  parameter int X_MAX       = 694,
  parameter int Y_MIN       = 111,
  parameter int Y_MAX       = 431,
  parameter int X_INIT      = 464,
  parameter int Y_INIT      = 271,
  parameter int SPD_W       = 4,
  parameter int VX_INIT     = 7,
  parameter int VY_INIT     = 3,
  parameter int SPD_MAX     = 15,
  parameter int CNT_W       = 8,
  parameter int ACCEL_EVERY = 4
) (
  input  logic          clk,
  input  logic          clr,
  bounce_mover_if.slave bus
);

  // Walls plus the fastest speed must fit in POS_W bits.
  if ((X_MAX + SPD_MAX >= 2**POS_W) || (Y_MAX + SPD_MAX >= 2**POS_W) || (ACCEL_EVERY < 1)) begin : g_bad_cfg
    $error("bounce_mover: illegal parameter combination");
  end

  logic [POS_W-1:0] pos_x_q, pos_y_q, pos_x_n, pos_y_n;
  logic [SPD_W-1:0] spd_x_q, spd_y_q, spd_x_n, spd_y_n;
  logic             dir_x_q, dir_y_q, dir_x_n, dir_y_n;
  logic             bnc_x_q, bnc_y_q, bnc_x_n, bnc_y_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             tick_d;
  logic             step;

  // A tick edge seen while paused or loading is consumed, not deferred.
  assign step = bus.tick & ~tick_d & ~bus.pause & ~bus.load;

`ifdef BOUNCE_MOVER_ACCEL_EN
  localparam int ACC_W = (ACCEL_EVERY > 1) ? $clog2(ACCEL_EVERY) : 1;
  logic [ACC_W-1:0] acc_q, acc_n;

  function automatic logic [SPD_W-1:0] spd_inc(input logic [SPD_W-1:0] s);
    if ((s == '0) || (s >= SPD_W'(SPD_MAX))) return s;
    return s + 1'b1;
  endfunction
`endif

  // One axis step in POS_W+1 bits so pos+spd never wraps; zero speed is inert.
  function automatic void move_axis(
    input  logic [POS_W-1:0] pos,
    input  logic [SPD_W-1:0] spd,
    input  logic             dir,
    input  logic [POS_W:0]   lo,
    input  logic [POS_W:0]   hi,
    output logic [POS_W-1:0] pos_n,
    output logic             dir_n,
    output logic             bnc
  );
    logic [POS_W:0] p, s, sum;
    p     = {1'b0, pos};
    s     = (POS_W+1)'(spd);
    sum   = p + s;
    pos_n = pos;
    dir_n = dir;
    bnc   = 1'b0;
    if (spd != '0) begin
      if (!dir) begin
        if (sum >= hi) begin
          pos_n = hi[POS_W-1:0];
          dir_n = 1'b1;
          bnc   = 1'b1;
        end else begin
          pos_n = sum[POS_W-1:0];
        end
      end else begin
        if (p <= lo + s) begin
          pos_n = lo[POS_W-1:0];
          dir_n = 1'b0;
          bnc   = 1'b1;
        end else begin
          pos_n = pos - POS_W'(spd);
        end
      end
    end
  endfunction

  // Next-state: load beats step; bounce pulses default low.
  always_comb begin
    pos_x_n = pos_x_q;
    pos_y_n = pos_y_q;
    spd_x_n = spd_x_q;
    spd_y_n = spd_y_q;
    dir_x_n = dir_x_q;
    dir_y_n = dir_y_q;
    bnc_x_n = 1'b0;
    bnc_y_n = 1'b0;
    cnt_n   = cnt_q;
`ifdef BOUNCE_MOVER_ACCEL_EN
    acc_n   = acc_q;
`endif
    if (bus.load) begin
      pos_x_n = bus.pos_x_in;
      pos_y_n = bus.pos_y_in;
      spd_x_n = bus.spd_x_in;
      spd_y_n = bus.spd_y_in;
      dir_x_n = bus.dir_x_in;
      dir_y_n = bus.dir_y_in;
`ifdef BOUNCE_MOVER_ACCEL_EN
      acc_n   = '0;
`endif
    end else if (step) begin
      move_axis(pos_x_q, spd_x_q, dir_x_q, (POS_W+1)'(X_MIN), (POS_W+1)'(X_MAX),
                pos_x_n, dir_x_n, bnc_x_n);
      move_axis(pos_y_q, spd_y_q, dir_y_q, (POS_W+1)'(Y_MIN), (POS_W+1)'(Y_MAX),
                pos_y_n, dir_y_n, bnc_y_n);
      if (bnc_x_n | bnc_y_n) begin
        if (cnt_q != '1) cnt_n = cnt_q + 1'b1;
`ifdef BOUNCE_MOVER_ACCEL_EN
        // Speed bump uses the pre-step speeds; the step above already used them.
        if (acc_q == ACC_W'(ACCEL_EVERY - 1)) begin
          acc_n   = '0;
          spd_x_n = spd_inc(spd_x_q);
          spd_y_n = spd_inc(spd_y_q);
        end else begin
          acc_n = acc_q + 1'b1;
        end
`endif
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pos_x_q <= POS_W'(X_INIT);
      pos_y_q <= POS_W'(Y_INIT);
      spd_x_q <= SPD_W'(VX_INIT);
      spd_y_q <= SPD_W'(VY_INIT);
      dir_x_q <= 1'b0;
      dir_y_q <= 1'b0;
      bnc_x_q <= 1'b0;
      bnc_y_q <= 1'b0;
      cnt_q   <= '0;
      tick_d  <= 1'b0;
`ifdef BOUNCE_MOVER_ACCEL_EN
      acc_q   <= '0;
`endif
    end else begin
      pos_x_q <= pos_x_n;
      pos_y_q <= pos_y_n;
      spd_x_q <= spd_x_n;
      spd_y_q <= spd_y_n;
      dir_x_q <= dir_x_n;
      dir_y_q <= dir_y_n;
      bnc_x_q <= bnc_x_n;
      bnc_y_q <= bnc_y_n;
      cnt_q   <= cnt_n;
      tick_d  <= bus.tick;
`ifdef BOUNCE_MOVER_ACCEL_EN
      acc_q   <= acc_n;
`endif
    end
  end

  assign bus.pos_x      = pos_x_q;
  assign bus.pos_y      = pos_y_q;
  assign bus.spd_x      = spd_x_q;
  assign bus.spd_y      = spd_y_q;
  assign bus.dir_x      = dir_x_q;
  assign bus.dir_y      = dir_y_q;
  assign bus.bounce_x   = bnc_x_q;
  assign bus.bounce_y   = bnc_y_q;
  assign bus.bounce_cnt = cnt_q;

endmodule
